adder_tree_pipe: RTL and testbench



---
 rtl/adder_tree_pipe.sv | 88 ++++++++
 tb/tb_adder_tree_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: N_IN channels summed over log2(N_IN) registered levels, full growth inside.
// Global enable stalls every level at once; define ADDER_TREE_SAT_EN to saturate the narrow (OUT_MODE=0) output.
module adder_tree_pipe #(
  parameter  int DIM      = 14,
  parameter  int N_IN     = 4,
  parameter  int OUT_MODE = 0,
  localparam int LOG2N    = $clog2(N_IN),
  localparam int FW       = DIM + LOG2N,
  localparam int OW       = (OUT_MODE == 1) ? FW : DIM
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN*DIM-1:0]  din,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [OW-1:0] sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf
);

  logic             w_en;
  logic [LOG2N:1]   r_vld;
  logic signed [FW-1:0] w_f;

  assign out_valid = r_vld[LOG2N];
  assign w_en      = out_ready | ~out_valid;
  assign in_ready  = w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld[1] <= in_valid;
      for (int i = 2; i <= LOG2N; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Level L entries are DIM+L bits wide; each sum sign-extends its two operands by one bit.
  genvar L, k;
  generate
    for (L = 0; L <= LOG2N; L++) begin : g_lvl
      localparam int NE = N_IN >> L;
      localparam int WL = DIM + L;
      logic signed [WL-1:0] w_s [NE];
      if (L == 0) begin : g_in
        for (k = 0; k < NE; k++) begin : g_ch
          assign w_s[k] = din[k*DIM +: DIM];
        end
      end else begin : g_add
        logic signed [WL-1:0] r_s [NE];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < NE; j++) r_s[j] <= '0;
          end else if (w_en) begin
            for (int j = 0; j < NE; j++)
              r_s[j] <= {g_lvl[L-1].w_s[2*j][WL-2],   g_lvl[L-1].w_s[2*j]} +
                        {g_lvl[L-1].w_s[2*j+1][WL-2], g_lvl[L-1].w_s[2*j+1]};
          end
        end
        for (k = 0; k < NE; k++) begin : g_o
          assign w_s[k] = r_s[k];
        end
      end
    end
  endgenerate

  assign w_f = g_lvl[LOG2N].w_s[0];

  generate
    if (OUT_MODE == 1) begin : g_full
      assign sum = w_f;
      assign ovf = 1'b0;
    end else begin : g_narrow
      // F fits in DIM bits exactly when all bits from the DIM-1 sign position upward agree.
      logic w_ovf;
      assign w_ovf = ~((&w_f[FW-1:DIM-1]) | ~(|w_f[FW-1:DIM-1]));
      assign ovf   = w_ovf;
`ifdef ADDER_TREE_SAT_EN
      assign sum = !w_ovf    ? w_f[DIM-1:0] :
                   w_f[FW-1] ? {1'b1, {(DIM-1){1'b0}}} : {1'b0, {(DIM-1){1'b1}}};
`else
      assign sum = w_f[DIM-1:0];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: narrow and full-growth 4-input trees plus an 8-input full-growth tree.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready;
  logic [55:0]  din4;
  logic [111:0] din8;

  logic               u0_in_ready, u0_out_valid, u0_ovf;
  logic signed [13:0] u0_sum;
  logic               u1_in_ready, u1_out_valid, u1_ovf;
  logic signed [15:0] u1_sum;
  logic               u8_in_ready, u8_out_valid, u8_ovf;
  logic signed [16:0] u8_sum;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_tree_pipe #(.DIM(14), .N_IN(4), .OUT_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din4), .in_valid(in_valid), .in_ready(u0_in_ready),
    .sum(u0_sum), .out_valid(u0_out_valid), .out_ready(out_ready), .ovf(u0_ovf));

  adder_tree_pipe #(.DIM(14), .N_IN(4), .OUT_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din4), .in_valid(in_valid), .in_ready(u1_in_ready),
    .sum(u1_sum), .out_valid(u1_out_valid), .out_ready(out_ready), .ovf(u1_ovf));

  adder_tree_pipe #(.DIM(14), .N_IN(8), .OUT_MODE(1)) u8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .in_valid(in_valid), .in_ready(u8_in_ready),
    .sum(u8_sum), .out_valid(u8_out_valid), .out_ready(out_ready), .ovf(u8_ovf));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int c0, c1, c2, c3;
    int f;      // full-growth sum
    int wrap;   // narrow, wrapped
    int sat;    // narrow, saturated
    int ovf;
  } vec_t;

  vec_t tv[8];

  initial begin
    longint prev_sum;
    bit     have_prev;
    int     sent, got, exp0;

    tv[0] = '{c0:100,   c1:-50, c2:7,  c3:1,  f:58,     wrap:58,   sat:58,    ovf:0};
    tv[1] = '{c0:8191,  c1:8191,  c2:8191,  c3:8191,  f:32764,  wrap:-4, sat:8191,  ovf:1};
    tv[2] = '{c0:-8192, c1:-8192, c2:-8192, c3:-8192, f:-32768, wrap:0,  sat:-8192, ovf:1};
    tv[3] = '{c0:8191,  c1:1,   c2:0,  c3:0,  f:8192,   wrap:-8192, sat:8191,  ovf:1};
    tv[4] = '{c0:-8192, c1:-1,  c2:0,  c3:0,  f:-8193,  wrap:8191,  sat:-8192, ovf:1};
    tv[5] = '{c0:8000,  c1:191, c2:0,  c3:0,  f:8191,   wrap:8191,  sat:8191,  ovf:0};
    tv[6] = '{c0:-8192, c1:0,   c2:0,  c3:0,  f:-8192,  wrap:-8192, sat:-8192, ovf:0};
    tv[7] = '{c0:-1,    c1:-1,  c2:-1, c3:-1, f:-4,     wrap:-4,    sat:-4,    ovf:0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din4 = '0; din8 = '0;
    #12;
    chk("rst_out_valid", u0_out_valid, 0);
    chk("rst_sum",       u0_sum, 0);
    chk("rst_ovf",       u0_ovf, 0);
    chk("rst_in_ready",  u0_in_ready, 1);
    chk("rst_u8_valid",  u8_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // One pulse per vector: valid must appear exactly two cycles later, for one cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      din4 = {14'(tv[i].c3), 14'(tv[i].c2), 14'(tv[i].c1), 14'(tv[i].c0)};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("vec_lat1_valid", u0_out_valid, 0);
      @(negedge clk);
`ifdef ADDER_TREE_SAT_EN
      exp0 = tv[i].sat;
`else
      exp0 = tv[i].wrap;
`endif
      chk("vec_lat2_valid", u0_out_valid, 1);
      chk("vec_narrow_sum", u0_sum, exp0);
      chk("vec_narrow_ovf", u0_ovf, tv[i].ovf);
      chk("vec_full_valid", u1_out_valid, 1);
      chk("vec_full_sum",   u1_sum, tv[i].f);
      chk("vec_full_ovf",   u1_ovf, 0);
      @(negedge clk);
      chk("vec_single_pulse", u0_out_valid, 0);
    end

    // Backpressure: stream 1..5 on all channels, out_ready low for three cycles mid-stream.
    sent = 0; got = 0; have_prev = 1'b0; prev_sum = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 5);
      din4      = {4{14'(sent + 1)}};
      #1;
      if (u0_out_valid && !out_ready) begin
        chk("bp_in_ready_stall", u0_in_ready, 0);
        if (have_prev) chk("bp_sum_stable", u0_sum, prev_sum);
        prev_sum  = u0_sum;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (u0_out_valid && out_ready) begin
        chk("bp_order", u0_sum, 4 * (got + 1));
        got++;
      end
      if (in_valid && u0_in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got, 5);
    @(negedge clk);
    chk("bp_no_dup", u0_out_valid, 0);

    // Reset with two samples in flight.
    @(negedge clk);
    din4 = {4{14'(1)}}; in_valid = 1'b1;
    @(negedge clk);
    din4 = {4{14'(2)}};
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full_valid", u0_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", u0_out_valid, 0);
    chk("mid_rst_sum",   u0_sum, 0);
    chk("mid_rst_full_sum", u1_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_flushed_valid", u0_out_valid, 0);
    end

    // Eight-input tree: channels k = k, three-cycle latency.
    @(negedge clk);
    for (int ch = 0; ch < 8; ch++) din8[ch*14 +: 14] = 14'(ch);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("n8_lat1_valid", u8_out_valid, 0);
    @(negedge clk);
    chk("n8_lat2_valid", u8_out_valid, 0);
    @(negedge clk);
    chk("n8_lat3_valid", u8_out_valid, 1);
    chk("n8_sum", u8_sum, 28);
    chk("n8_ovf", u8_ovf, 0);
    @(negedge clk);
    chk("n8_single_pulse", u8_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
